fifo_wptr_wfull: RTL and testbench

Write-side pointer and full-flag generator for a dual-clock (asynchronous) FIFO, operating entirely in the write clock domain.
- Keeps a binary write counter that drives the memory write address.
- Publishes the write pointer in Gray code for synchronisation into the read domain.
- Raises a registered full flag by comparing its next Gray pointer with the read pointer already synchronised into the write domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_bin2gray.sv | 17 +
 rtl/fifo_wptr_wfull.sv | 57 +++++
 tb/tb_fifo_wptr_wfull.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helper for the async FIFO pointer blocks.
package fifo_pkg;

    localparam int DEF_ADDRESS = 3;
    localparam int DEF_PTR_W   = DEF_ADDRESS + 1;
    localparam int GRAY_MAX_W  = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] i_bin);
        return (i_bin >> 1) ^ i_bin;
    endfunction

endpackage

// File: rtl/fifo_bin2gray.sv
// Binary to Gray converter, width W, purely combinational.
// Latency: none. Backpressure: not applicable.
module fifo_bin2gray
    import fifo_pkg::*;
#(
    parameter int W = DEF_PTR_W
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    logic [GRAY_MAX_W-1:0] w_gray_ext;

    assign w_gray_ext = bin2gray(GRAY_MAX_W'(i_bin));
    assign o_gray     = w_gray_ext[W-1:0];

endmodule

// File: rtl/fifo_wptr_wfull.sv
// Write-side pointer and registered full flag for a dual-clock FIFO.
// Latency: pointers and full update on the edge of the write; Winc is ignored while full.
module fifo_wptr_wfull
    import fifo_pkg::*;
#(
    parameter int Address = DEF_ADDRESS
) (
    input  logic               Wclk,
    input  logic               Wrst,
    input  logic               Winc,
    input  logic [Address:0]   Wq2_rptr,
    output logic [Address-1:0] Wadder,
    output logic [Address:0]   Wptr,
    output logic               Wfull
);

    logic [Address:0] r_wbin;
    logic [Address:0] r_wptr;
    logic             r_wfull;

    logic             w_wr_ok;
    logic [Address:0] w_wbin_next;
    logic [Address:0] w_wgray_next;
    logic [Address:0] w_rptr_lap;
    logic             w_full_next;

    assign w_wr_ok     = Winc & ~r_wfull;
    assign w_wbin_next = r_wbin + {{Address{1'b0}}, w_wr_ok};

    fifo_bin2gray #(
        .W (Address + 1)
    ) u_bin2gray (
        .i_bin  (w_wbin_next),
        .o_gray (w_wgray_next)
    );

    // One full lap ahead in Gray space means the top two bits differ, the rest match.
    assign w_rptr_lap  = {~Wq2_rptr[Address:Address-1], Wq2_rptr[Address-2:0]};
    assign w_full_next = (w_wgray_next == w_rptr_lap);

    always_ff @(posedge Wclk or posedge Wrst) begin
        if (Wrst) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wgray_next;
            r_wfull <= w_full_next;
        end
    end

    assign Wadder = r_wbin[Address-1:0];
    assign Wptr   = r_wptr;
    assign Wfull  = r_wfull;

endmodule

// File: tb/tb_fifo_wptr_wfull.sv
// Directed bench for fifo_wptr_wfull at Address=3: reset, fill, hold-when-full, release, wrap, mid-run reset.
module tb_fifo_wptr_wfull;

    logic       Wclk;
    logic       Wrst;
    logic       Winc;
    logic [3:0] Wq2_rptr;
    logic [2:0] Wadder;
    logic [3:0] Wptr;
    logic       Wfull;

    int n_chk = 0;
    int n_err = 0;

    fifo_wptr_wfull #(
        .Address (3)
    ) dut (
        .Wclk     (Wclk),
        .Wrst     (Wrst),
        .Winc     (Winc),
        .Wq2_rptr (Wq2_rptr),
        .Wadder   (Wadder),
        .Wptr     (Wptr),
        .Wfull    (Wfull)
    );

    initial Wclk = 1'b0;
    always #5 Wclk = ~Wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [2:0] fill_adr [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [3:0] fill_ptr [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    logic [3:0] m_wbin;
    logic [3:0] m_rbin;
    logic [3:0] m_prev;
    logic       m_full;
    logic       m_acc;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Wrst     = 1'b1;
        Winc     = 1'b1;
        Wq2_rptr = 4'h0;

        repeat (3) begin
            @(negedge Wclk);
            chk("rst_wptr", Wptr, 0);
            chk("rst_wadr", Wadder, 0);
            chk("rst_full", Wfull, 0);
        end
        @(negedge Wclk);
        Wrst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(posedge Wclk);
            #1;
            chk("fill_wadr", Wadder, fill_adr[i]);
            chk("fill_wptr", Wptr, fill_ptr[i]);
            chk("fill_full", Wfull, (i == 7) ? 1 : 0);
        end

        for (int i = 0; i < 4; i++) begin
            @(posedge Wclk);
            #1;
            chk("hold_wptr", Wptr, 4'hC);
            chk("hold_wadr", Wadder, 0);
            chk("hold_full", Wfull, 1);
        end

        Winc     = 1'b0;
        Wq2_rptr = 4'h1;
        @(posedge Wclk);
        #1;
        chk("rel_full", Wfull, 0);
        chk("rel_wptr", Wptr, 4'hC);
        Winc = 1'b1;
        @(posedge Wclk);
        #1;
        chk("rel1_wptr", Wptr, 4'hD);
        chk("rel1_wadr", Wadder, 1);
        chk("rel1_full", Wfull, 1);

        // Occupancy model: full exactly when writes lead reads by 8 (mod 16).
        m_wbin = 4'd9;
        m_rbin = 4'd1;
        m_full = 1'b1;
        for (int i = 0; i < 27; i++) begin
            if (i % 3 != 0) m_rbin = m_rbin + 4'd1;
            Wq2_rptr = gray4(m_rbin);
            Winc     = 1'b1;
            @(posedge Wclk);
            #1;
            m_acc  = ~m_full;
            m_prev = m_wbin;
            m_wbin = m_wbin + {3'd0, m_acc};
            m_full = ((m_wbin - m_rbin) == 4'd8);
            chk("wrap_wadr", Wadder, m_wbin[2:0]);
            chk("wrap_wptr", Wptr, gray4(m_wbin));
            chk("wrap_full", Wfull, m_full);
            if (m_prev == 4'hF && m_wbin == 4'h0) chk("wrap_zero", Wptr, 0);
        end

        Winc = 1'b0;
        Wrst = 1'b1;
        #2;
        Wrst     = 1'b0;
        Wq2_rptr = 4'h0;
        Winc     = 1'b1;
        repeat (5) @(posedge Wclk);
        #1;
        chk("mid_pre_wadr", Wadder, 5);
        chk("mid_pre_wptr", Wptr, 4'h7);
        #2;
        Wrst = 1'b1;
        #1;
        chk("mid_rst_wptr", Wptr, 0);
        chk("mid_rst_wadr", Wadder, 0);
        chk("mid_rst_full", Wfull, 0);
        Winc = 1'b0;
        #2;
        Wrst = 1'b0;
        #1;
        chk("mid_rel_wadr", Wadder, 0);
        chk("mid_rel_wptr", Wptr, 0);
        Winc = 1'b1;
        @(posedge Wclk);
        #1;
        chk("mid_w1_wadr", Wadder, 1);
        chk("mid_w1_wptr", Wptr, 4'h1);
        chk("mid_w1_full", Wfull, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
